sprite_blitter: RTL and testbench

- Producer side of the frame-buffer write path.
- Accepts one draw command per handshake: sprite base address in sprite ROM, screen origin, width, height, optional horizontal flip.
- Walks the sprite row-major, fetches 5-bit encoded pixels from sprite ROM, and issues frame-buffer write strobes. Strobes occur only during blanking, are clipped to the 640x480 screen, and skip the transparent code.

---
 rtl/sprite_blitter_if.sv | 37 +++
 rtl/sprite_blitter.sv | 198 +++++++++++++++++++
 tb/tb_sprite_blitter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Command, sprite-ROM and frame-buffer signals of the sprite blitter.
// slave is the blitter side; master is the side that feeds it commands,
// ROM data and blanking.
interface sprite_blitter_if #(
    parameter int PIX_W  = 5,
    parameter int DIM_W  = 6,
    parameter int ROM_AW = 16
);
    logic              blank;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ROM_AW-1:0] cmd_base;
    logic [9:0]        cmd_x;
    logic [9:0]        cmd_y;
    logic [DIM_W-1:0]  cmd_w;
    logic [DIM_W-1:0]  cmd_h;
    logic              cmd_flip;
    logic [ROM_AW-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_data;
    logic              fb_we;
    logic [18:0]       fb_addr;
    logic [PIX_W-1:0]  fb_data;
    logic              busy;
    logic              done;

    modport slave (
        input  blank, cmd_valid, cmd_base, cmd_x, cmd_y, cmd_w, cmd_h, cmd_flip,
        input  rom_data,
        output cmd_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );

    modport master (
        output blank, cmd_valid, cmd_base, cmd_x, cmd_y, cmd_w, cmd_h, cmd_flip,
        output rom_data,
        input  cmd_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a sprite row-major, reads encoded pixels from the
// sprite ROM (1-cycle read latency) and writes them to the frame buffer
// during blanking, clipped to the screen and skipping the transparent code.
module sprite_blitter #(
    parameter int              SCREEN_W    = 640,
    parameter int              SCREEN_H    = 480,
    parameter int              PIX_W       = 5,
    parameter logic [PIX_W-1:0] TRANSPARENT = 5'h15,
    parameter int              DIM_W       = 6,
    parameter int              ROM_AW      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    sprite_blitter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] base_q, base_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic [DIM_W-1:0]  w_q, w_d;
    logic [DIM_W-1:0]  h_q, h_d;
    logic              flip_q, flip_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              fb_we_q, fb_we_d;
    logic [18:0]       fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]  fb_data_q, fb_data_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Working values for the pixel under decision in WRITE.
    logic [10:0]       sx, sy;
    logic              in_range;
    logic              last_pix;
    logic [DIM_W-1:0]  col_nxt, row_nxt;

    // ROM address of sprite pixel (row, col), mirrored when flip is set.
    // Wraps at ROM_AW bits.
    function automatic logic [ROM_AW-1:0] pix_addr(
        input logic [ROM_AW-1:0] base,
        input logic [DIM_W-1:0]  row,
        input logic [DIM_W-1:0]  col,
        input logic [DIM_W-1:0]  w,
        input logic              flip
    );
        logic [DIM_W-1:0]   off;
        logic [2*DIM_W-1:0] prod;
        off  = flip ? (w - col - DIM_W'(1)) : col;
        prod = {{DIM_W{1'b0}}, row} * {{DIM_W{1'b0}}, w};
        return base + ROM_AW'(prod) + ROM_AW'(off);
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves
        // a variable unassigned, which would infer a latch.
        state_d     = state_q;
        base_d      = base_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        h_d         = h_q;
        flip_d      = flip_q;
        row_d       = row_q;
        col_d       = col_q;
        rom_addr_d  = rom_addr_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;

        sx       = 11'(x_q) + 11'(col_q);
        sy       = 11'(y_q) + 11'(row_q);
        in_range = (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));
        last_pix = (row_q == h_q - DIM_W'(1)) && (col_q == w_q - DIM_W'(1));
        if (col_q == w_q - DIM_W'(1)) begin
            col_nxt = '0;
            row_nxt = row_q + DIM_W'(1);
        end else begin
            col_nxt = col_q + DIM_W'(1);
            row_nxt = row_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    base_d = bus.cmd_base;
                    x_d    = bus.cmd_x;
                    y_d    = bus.cmd_y;
                    w_d    = bus.cmd_w;
                    h_d    = bus.cmd_h;
                    flip_d = bus.cmd_flip;
                    row_d  = '0;
                    col_d  = '0;
                    if (bus.cmd_w == '0 || bus.cmd_h == '0) begin
                        state_d = DONE;
                    end else begin
                        // The address is registered on entry to FETCH so the
                        // ROM data lands in WRITE.
                        rom_addr_d = pix_addr(bus.cmd_base, '0, '0, bus.cmd_w, bus.cmd_flip);
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                state_d = WRITE;
            end
            WRITE: begin
                // rom_addr is held here, so rom_data stays valid across stalls.
                if (bus.blank) begin
                    if (in_range && bus.rom_data != TRANSPARENT) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = 19'(sy) * 19'(SCREEN_W) + 19'(sx);
                        fb_data_d = bus.rom_data;
                    end
                    col_d = col_nxt;
                    row_d = row_nxt;
                    if (last_pix) begin
                        state_d = DONE;
                    end else begin
                        rom_addr_d = pix_addr(base_q, row_nxt, col_nxt, w_q, flip_q);
                        state_d    = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; all state is reset, including the command
        // latches, so a restarted block never sees stale fields.
        if (!Reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            flip_q      <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            rom_addr_q  <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            flip_q      <= flip_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rom_addr_q  <= rom_addr_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.fb_we     = fb_we_q;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_data   = fb_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter. Stimulus pushes the expected frame-buffer
// writes into a queue; a negedge monitor pops and compares each fb_we pulse.
module tb_sprite_blitter;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    sprite_blitter_if bus ();

    sprite_blitter dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [18:0] addr;
        logic [4:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    int         n_cmp    = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         acc_cyc  = 0;
    logic       mon_en   = 1'b0;
    logic       blank_at_edge = 1'b1;
    logic [4:0] rom_mem [0:4095];

    // Cycle counter, blank capture at the decision edge, 1-cycle-latency ROM.
    always @(posedge Clk) begin
        cyc           <= cyc + 1;
        blank_at_edge <= bus.blank;
        bus.rom_data  <= rom_mem[bus.rom_addr[11:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is compared against the scoreboard head.
    always @(negedge Clk) begin
        wr_t e;
        if (mon_en) begin
            if (bus.done === 1'b1) done_cnt++;
            if (bus.fb_we === 1'b1) begin
                check("we_only_in_blank", {31'b0, blank_at_edge}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                             bus.fb_addr, bus.fb_data);
                end else begin
                    e = exp_q.pop_front();
                    check("fb_write", {8'b0, bus.fb_addr, bus.fb_data}, {8'b0, e});
                end
            end
        end
    end

    task automatic push_wr(input logic [18:0] addr, input logic [4:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Present a command and return at the negedge after the accept edge.
    task automatic send(input logic [15:0] base, input logic [9:0] x, input logic [9:0] y,
                        input logic [5:0] w, input logic [5:0] h, input logic flip,
                        input logic keep_valid);
        int t;
        @(negedge Clk);
        bus.cmd_base  = base;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_flip  = flip;
        bus.cmd_valid = 1'b1;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got cmd_ready=%b, expected 1", bus.cmd_ready);
        end
        @(negedge Clk);
        acc_cyc = cyc;
        // Scramble the fields; a busy block must ignore them.
        bus.cmd_base  = 16'h0A00;
        bus.cmd_x     = 10'd1;
        bus.cmd_y     = 10'd1;
        bus.cmd_w     = 6'd7;
        bus.cmd_h     = 6'd7;
        bus.cmd_flip  = 1'b1;
        bus.cmd_valid = keep_valid;
    endtask

    // Wait for done, then check latency, pulse width, pulse count and drain.
    task automatic wait_done(input string tag, input int exp_lat, input int done_before);
        int t;
        t = 0;
        while (bus.done !== 1'b1 && t < 300) begin
            @(negedge Clk);
            t++;
        end
        bus.cmd_valid = 1'b0;
        if (t >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_done_timeout: got no done, expected done within 300 cycles", tag);
        end else begin
            check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
        end
        @(negedge Clk);
        check({tag, "_done_one_cycle"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt - done_before), 32'd1);
        check({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        bus.blank     = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_flip  = 1'b0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 5'd0;
        rom_mem[12'h100] = 5'd3;  rom_mem[12'h101] = 5'd4;
        rom_mem[12'h102] = 5'd5;  rom_mem[12'h103] = 5'd6;
        rom_mem[12'h200] = 5'd7;  rom_mem[12'h201] = 5'd8;
        rom_mem[12'h202] = 5'd9;  rom_mem[12'h203] = 5'd10;
        rom_mem[12'h300] = 5'd9;  rom_mem[12'h301] = 5'd10;
        rom_mem[12'h400] = 5'd1;  rom_mem[12'h401] = 5'd2;

        // Reset held low for two edges.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check("rst_busy",      {31'b0, bus.busy},      32'd0);
        check("rst_fb_we",     {31'b0, bus.fb_we},     32'd0);
        check("rst_done",      {31'b0, bus.done},      32'd0);
        check("rst_fb_addr",   {13'b0, bus.fb_addr},   32'd0);
        check("rst_rom_addr",  {16'b0, bus.rom_addr},  32'd0);
        mon_en = 1'b1;

        // Basic 2x2 sprite at (10,20).
        d0 = done_cnt;
        push_wr(19'd12810, 5'd3); push_wr(19'd12811, 5'd4);
        push_wr(19'd13450, 5'd5); push_wr(19'd13451, 5'd6);
        send(16'h0100, 10'd10, 10'd20, 6'd2, 6'd2, 1'b0, 1'b0);
        wait_done("basic", 8, d0);
        check("hold_fb_addr", {13'b0, bus.fb_addr}, 32'd13451);
        check("hold_fb_data", {27'b0, bus.fb_data}, 32'd6);

        // Horizontal flip: columns swapped within each row.
        d0 = done_cnt;
        push_wr(19'd12810, 5'd4); push_wr(19'd12811, 5'd3);
        push_wr(19'd13450, 5'd6); push_wr(19'd13451, 5'd5);
        send(16'h0100, 10'd10, 10'd20, 6'd2, 6'd2, 1'b1, 1'b0);
        wait_done("flip", 8, d0);

        // Transparent code at 0x0101: address 12811 never written.
        rom_mem[12'h101] = 5'h15;
        d0 = done_cnt;
        push_wr(19'd12810, 5'd3);
        push_wr(19'd13450, 5'd5); push_wr(19'd13451, 5'd6);
        send(16'h0100, 10'd10, 10'd20, 6'd2, 6'd2, 1'b0, 1'b0);
        wait_done("transparent", 8, d0);

        // Bottom-right corner: only pixel (0,0) is on screen.
        d0 = done_cnt;
        push_wr(19'd307199, 5'd7);
        send(16'h0200, 10'd639, 10'd479, 6'd2, 6'd2, 1'b0, 1'b0);
        wait_done("clip", 8, d0);

        // Zero width: straight to DONE, no reads or writes.
        d0 = done_cnt;
        send(16'h0100, 10'd10, 10'd20, 6'd0, 6'd3, 1'b0, 1'b0);
        wait_done("zero_w", 0, d0);

        // Blank low for 5 cycles in the first WRITE; a second command is
        // held valid throughout and must be ignored while busy.
        d0 = done_cnt;
        push_wr(19'd0, 5'd9); push_wr(19'd1, 5'd10);
        send(16'h0300, 10'd0, 10'd0, 6'd2, 6'd1, 1'b0, 1'b1);
        @(negedge Clk);
        bus.blank = 1'b0;
        repeat (5) @(negedge Clk);
        bus.blank = 1'b1;
        wait_done("stall", 9, d0);

        // Reset mid-sprite after the second write: no more writes, no done.
        d0 = done_cnt;
        push_wr(19'd128100, 5'd1); push_wr(19'd128101, 5'd2);
        send(16'h0400, 10'd100, 10'd200, 6'd4, 6'd4, 1'b0, 1'b0);
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        check("abort_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check("abort_busy",      {31'b0, bus.busy},      32'd0);
        check("abort_fb_we",     {31'b0, bus.fb_we},     32'd0);
        repeat (10) @(negedge Clk);
        check("abort_no_done",   32'(done_cnt - d0),     32'd0);
        check("abort_drained",   32'(exp_q.size()),      32'd0);
        check("abort_idle_ready", {31'b0, bus.cmd_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog in case the run stops making progress.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
